// File: rtl/csel_subtractor_if.sv
// ---------------------------------------------------------------------------
// csel_subtractor_if
// Operand/result handshake bundle for csel_subtractor.
//   in_valid/in_ready : operand request handshake (A, B, bin qualified by it)
//   A, B, bin         : minuend, subtrahend, borrow-in
//   out_valid/out_ready : result handshake (diff, bout, ovf qualified by it)
//   diff, bout, ovf   : difference, borrow-out, two's-complement overflow
// Modports: master = requester/consumer side, slave = the subtractor.
// ---------------------------------------------------------------------------
interface csel_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, A, B, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, A, B, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/csel_subtractor.sv
// ---------------------------------------------------------------------------
// csel_subtractor
// Multi-cycle unsigned subtractor computing diff = A - B - bin (mod 2^WIDTH),
// one BLK-bit block per cycle. Each block precomputes both borrow-in
// alternatives and the running borrow picks one (carry-select style).
// Ports:
//   clk       : single clock, rising edge
//   rst       : synchronous, active-high reset
//   io        : csel_subtractor_if.slave (operand and result handshakes)
// Latency: out_valid rises WIDTH/BLK cycles after the accepting edge.
// ---------------------------------------------------------------------------
module csel_subtractor #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic                clk,
    input  logic                rst,
    csel_subtractor_if.slave    io
);
    localparam int NBLK = WIDTH / BLK;
    localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBLK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  diff_q;
    logic [IDXW-1:0]   idx_q;
    logic              borrow_q;
    logic              bout_q;
    logic              ovf_q;

    logic [BLK-1:0]    a_blk;
    logic [BLK-1:0]    b_blk;
    logic [BLK:0]      d0;
    logic [BLK:0]      d1;
    logic [BLK:0]      sel;
    logic              last_blk;

    // Both block results are formed every cycle; bit BLK is the block borrow.
    always_comb begin
        a_blk    = a_q[idx_q*BLK +: BLK];
        b_blk    = b_q[idx_q*BLK +: BLK];
        d0       = {1'b0, a_blk} - {1'b0, b_blk};
        d1       = {1'b0, a_blk} - {1'b0, b_blk} - {{BLK{1'b0}}, 1'b1};
        sel      = borrow_q ? d1 : d0;
        last_blk = (idx_q == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.in_valid)  state_d = CALC;
            CALC:    if (last_blk)     state_d = DONE;
            DONE:    if (io.out_ready) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        a_q      <= io.A;
                        b_q      <= io.B;
                        borrow_q <= io.bin;
                        idx_q    <= '0;
                    end
                end
                CALC: begin
                    diff_q[idx_q*BLK +: BLK] <= sel[BLK-1:0];
                    borrow_q                 <= sel[BLK];
                    if (last_blk) begin
                        // sel[BLK-1] is the result MSB written this cycle.
                        bout_q <= sel[BLK];
                        ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                  (sel[BLK-1] != a_q[WIDTH-1]);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);
    // Partially assembled results stay hidden until the result is complete.
    assign io.diff      = (state_q == DONE) ? diff_q : '0;
    assign io.bout      = bout_q;
    assign io.ovf       = ovf_q;
endmodule

// File: doc/csel_subtractor.md
CSEL_SUBTRACTOR -- requirements
Module: csel_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 SHALL have parameter BLK, default 4, block width in bits processed per CALC cycle; WIDTH SHALL be a multiple of BLK; NBLK = WIDTH/BLK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port A  input  WIDTH  minuend.
REQ-008 SHALL have port B  input  WIDTH  subtrahend.
REQ-009 SHALL have port bin  input  1  borrow-in.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port diff  output  WIDTH  A - B - bin, modulo 2^WIDTH.
REQ-013 SHALL have port bout  output  1  borrow-out; 1 iff A < B + bin, unsigned.
REQ-014 SHALL have port ovf  output  1  two's-complement overflow flag.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 IDLE: on in_valid=1 at an edge, SHALL latch A, B and bin, clear block index to 0, and go to CALC; otherwise SHALL stay in IDLE.
REQ-018 CALC: each cycle SHALL process block idx (bits idx*BLK+BLK-1 : idx*BLK). It SHALL precompute A_blk - B_blk - 0 and A_blk - B_blk - 1, then select one by the running borrow, carry-select style. It SHALL write the selected BLK bits into diff and the selected borrow into the running borrow.
REQ-019 Running borrow SHALL start at the latched bin for idx=0.
REQ-020 CALC: after processing idx = NBLK-1, the FSM SHALL go to DONE. It SHALL load bout from the final borrow and set ovf = (A[MSB] != B[MSB]) and (diff[MSB] != A[MSB]). Otherwise idx SHALL increment by 1.
REQ-021 Latency: out_valid SHALL go high exactly NBLK cycles after the accepting edge (4 for the defaults).
REQ-022 DONE: diff, bout and ovf SHALL hold stable while out_ready=0. On an edge with out_ready=1 the FSM SHALL go to IDLE.
REQ-023 The block SHALL have no overlap: in_valid SHALL be ignored in CALC and DONE. After a result hands off, the next operand accept SHALL occur no earlier than the following edge.
REQ-024 Latched operands SHALL be unaffected by changes on A, B or bin after the accepting edge.
REQ-025 diff bits of blocks not yet processed in CALC SHALL be don't-care. They SHALL NOT be observable while out_valid=0.
REQ-026 Arithmetic SHALL be unsigned modulo 2^WIDTH. Intermediate block differences SHALL be BLK+1 bits, with the MSB giving that block's borrow.

Reset
REQ-027 With rst=1 at an edge, the block SHALL go to IDLE and set in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, idx=0, running borrow=0.
REQ-028 rst SHALL take priority over every other input, including mid-CALC and DONE. An in-flight operation SHALL be discarded without producing any out_valid pulse.
REQ-029 On the first edge after rst deasserts, the block SHALL be able to accept an operand.

Verification
REQ-030 A=0x1234, B=0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0; out_valid high 4 cycles after accept.
REQ-031 A=0x0000, B=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0; borrow ripples through all 4 blocks.
REQ-032 A=0x8000, B=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Also A=0x7FFF, B=0xFFFF, bin=0 -> diff=0x8000, bout=1, ovf=1.
REQ-033 A=0x0010, B=0x000F, bin=1 -> diff=0x0000, bout=0; verifies that bin and the inter-block borrow select the correct block result.
REQ-034 Backpressure case:
- Stimulus: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
- Required: diff, bout and ovf stay stable and in_ready=0. After out_ready=1, the FSM returns to IDLE and the next operand is accepted one edge later.
REQ-035 Reset cases:
- Stimulus: assert rst during CALC idx=2.
- Required: the next edge gives IDLE, in_ready=1, out_valid=0 and diff=0, with no stale result afterwards.
- Stimulus: a back-to-back random sweep of 10k operand pairs (bin random) checked against a reference model.
- Required: every out_valid result matches the model.
